i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter that drains the sine synthesiser. Once per stereo frame it pulses the synthesiser's sample strobe, which drives `query_sine`. It then captures the returned mono sample and shifts it MSB-first to an external DAC on both channels. It generates the bit clock (`sclk`), the word select (`lrclk`) and the serial data (`sdata`). Standard I2S framing is the default; left-justified framing is a build option.

## Interface
- DATA_WDTH, 24, sample width; must match the synthesiser output width.
- FRAME_BITS, 32, sclk periods per channel slot; must be ≥ DATA_WDTH+1.
- SCLK_DIV, 8, clk cycles per sclk half-period; must be ≥ 1.
- REQ_LAT, 2, clk cycles from `sample_req` to the capture of `sample_in`; must be in 1..2*SCLK_DIV-1.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request.
- sample_req  output  1  one-clk strobe asking for the next sample.
- sample_in  input  DATA_WDTH  two's-complement sample from the synthesiser.
- sclk  output  1  bit clock.
- lrclk  output  1  word select: 0 = left slot, 1 = right slot.
- sdata  output  1  serial data.

## Operation
- States:
  - IDLE: sclk, lrclk and sdata are held 0; the dividers are cleared.
  - RUN: frames are transmitted continuously.
  - DRAIN: the current frame is finished, then the block returns to IDLE.
- State transitions:
  - IDLE→RUN when `en`=1.
  - RUN→DRAIN when `en`=0.
  - DRAIN→RUN when `en`=1; the frame continues with no gap.
  - DRAIN→IDLE on the last clk of the frame.
- Divider `div_cnt` counts 0..SCLK_DIV-1. On its terminal count, `sclk` toggles.
- Bit counter `bit_cnt` counts 0..2*FRAME_BITS-1 and advances on every sclk falling toggle.
- Framing signals:
  - `lrclk` = (bit_cnt ≥ FRAME_BITS).
  - Slot position p = bit_cnt mod FRAME_BITS.
- Holding register `hold`, reset value 0:
  - Loaded with `sample_in` exactly REQ_LAT clks after each `sample_req`.
  - Copied into the shift register at p=0 of both slots. The same sample therefore goes out on left and right.
- I2S mode (default):
  - p=0 carries 0.
  - p=1..DATA_WDTH carries hold[DATA_WDTH-p].
  - The remaining positions carry 0.
- `sample_req` pulses for one clk at the falling-edge toggle that sets bit_cnt = 2*FRAME_BITS-1. It pulses only in RUN and is suppressed in DRAIN.
- The first frame after leaving IDLE transmits the current `hold` value, which is 0 after reset.
- The sample is passed through as a raw two's-complement bit pattern. The block does no truncation and no sign handling.

## Timing
- Reset values: sclk=0, lrclk=0, sdata=0, sample_req=0, state=IDLE, hold=0.
- `rst` asserted mid-frame forces all outputs to 0 immediately, with no clock needed. The frame is abandoned.
- Start-up after IDLE→RUN (the clk edge that samples en=1):
  - On that edge: bit_cnt=0, lrclk=0, sdata = position-0 bit.
  - The first sclk rising edge follows SCLK_DIV clks later.
- sclk period = 2*SCLK_DIV clks. Frame = 4*FRAME_BITS*SCLK_DIV clks.
- Edge alignment:
  - lrclk and sdata change only on the clk edge where sclk goes 1→0.
  - The DAC samples on the sclk rising edge.
- `sample_req` is coincident with the sclk falling edge that starts the final bit of the frame.
- `sample_in` is captured REQ_LAT clks after `sample_req`, which is before the next falling edge. That falling edge starts frame p=0.
- `sample_in` is don't-care outside the capture cycle.
- `en` deasserted and reasserted within one frame produces no visible gap or phase change.

## Configuration
- I2S_TX_LEFT_JUSTIFIED_EN:
  - Defined: left-justified framing. p=0..DATA_WDTH-1 carries hold[DATA_WDTH-1-p]; the remaining positions carry 0. The MSB is aligned with the lrclk edge.
  - Undefined: standard I2S framing, with the MSB delayed one sclk after the lrclk edge.
  - Clocking, `sample_req` timing and state behaviour are identical in both modes.

## Test plan
All scenarios use DATA_WDTH=24, FRAME_BITS=32, SCLK_DIV=2, REQ_LAT=2, so one frame is 256 clks.

1. Reset then en=1 → sclk period 4 clks; lrclk toggles every 128 clks; first frame sdata is all 0; `sample_req` first pulses 252 clks after the start.
2. Return `sample_in`=0xA5C3F1 two clks after `sample_req` → next frame, I2S mode: both slots carry 0, then 101001011100001111110001 MSB-first, then 7 zeros.
3. The same stimulus with I2S_TX_LEFT_JUSTIFIED_EN defined → the MSB '1' appears at p=0 of each slot; 8 trailing zeros; `sample_req` timing is unchanged.
4. en=0 at mid-left-slot → the frame completes (bit_cnt reaches 63); no `sample_req` is issued; then IDLE with sclk=lrclk=sdata=0. Separately, en dropped for 10 clks then reasserted → continuous frames with no `sample_req` loss outside DRAIN.
5. `rst` pulsed at bit_cnt=40 → outputs go to 0 asynchronously; after release with en=1, framing restarts at bit_cnt=0 and the first frame carries 0.
6. `sample_in` value 0x800000 (full-scale negative) → serial pattern 1 followed by 23 zeros; no sign corruption.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: requests one mono sample per frame and sends it MSB-first on both slots.
// Build option I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing instead of standard I2S.
module i2s_tx #(
  parameter int unsigned DATA_WDTH  = 24,
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned SCLK_DIV   = 8,
  parameter int unsigned REQ_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 sample_req,
  input  logic [DATA_WDTH-1:0] sample_in,
  output logic                 sclk,
  output logic                 lrclk,
  output logic                 sdata
);

  localparam int unsigned BIT_W = $clog2(2 * FRAME_BITS);
  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned LAT_W = $clog2(REQ_LAT + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_BIT = BIT_W'(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic [LAT_W-1:0]     cap_cnt;
  logic [DATA_WDTH-1:0] hold;
  logic [DATA_WDTH-1:0] shreg;
  logic                 tick;
  logic                 fall;
  logic                 frame_end;
  logic                 slot_start;
  logic                 start_c;
  logic                 stop_c;
  logic                 run_c;
  logic                 req_c;
  logic                 first_bit;
  logic [DATA_WDTH-1:0] first_word;

  assign tick       = (div_cnt == DIV_TC);
  assign fall       = tick && sclk;
  assign frame_end  = fall && (bit_cnt == LAST_BIT);
  assign bit_nxt    = frame_end ? '0 : bit_cnt + 1'b1;
  assign slot_start = (bit_nxt == '0) || (bit_nxt == SLOT_BIT);

  // Bit driven at p=0 and the word left in the shifter for p=1 onward.
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  always_comb begin
    first_bit  = hold[DATA_WDTH-1];
    first_word = hold << 1;
  end
`else
  always_comb begin
    first_bit  = 1'b0;
    first_word = hold;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt = RUN;
        end else if (frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    stop_c  = 1'b0;
    run_c   = 1'b0;
    req_c   = 1'b0;
    start_c = (state == IDLE) && (state_nxt == RUN);
    stop_c  = (state == DRAIN) && (state_nxt == IDLE);
    run_c   = (state != IDLE) && !stop_c;
    // Request lands on the falling edge that opens the last bit of the frame.
    req_c   = (state == RUN) && fall && (bit_nxt == LAST_BIT);
  end

  // Clock generation, framing and serialiser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      sample_req <= 1'b0;
      shreg      <= '0;
    end else begin
      sample_req <= req_c;
      if (start_c) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= first_bit;
        shreg   <= first_word;
      end else if (run_c) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          sclk <= ~sclk;
        end
        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk   <= (bit_nxt >= SLOT_BIT);
          if (slot_start) begin
            sdata <= first_bit;
            shreg <= first_word;
          end else begin
            sdata <= shreg[DATA_WDTH-1];
            shreg <= {shreg[DATA_WDTH-2:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end
    end
  end

  // Sample capture a fixed latency after each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_cnt <= '0;
      hold    <= '0;
    end else begin
      if (req_c) begin
        cap_cnt <= LAT_W'(REQ_LAT);
      end else if (cap_cnt != '0) begin
        cap_cnt <= cap_cnt - 1'b1;
      end
      if (cap_cnt == LAT_W'(1)) begin
        hold <= sample_in;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame timing, serial data, drain, glitch-free en and async reset.
module tb_i2s_tx;

  localparam int unsigned W = 24;
  localparam int unsigned F = 32;
  localparam int unsigned D = 2;
  localparam int unsigned L = 2;
  localparam logic [W-1:0] JUNK = 24'h3C3C3C;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int MSB_K = 2;
`else
  localparam int MSB_K = 6;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] sample_in;
  logic         sample_req;
  logic         sclk;
  logic         lrclk;
  logic         sdata;
  logic [W-1:0] next_sample;

  int errors = 0;
  int checks = 0;

  logic sc[0:299];
  logic lr[0:299];
  logic sd[0:299];
  logic rq[0:299];

  always #5 clk = ~clk;

  i2s_tx #(
    .DATA_WDTH (W),
    .FRAME_BITS(F),
    .SCLK_DIV  (D),
    .REQ_LAT   (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample_req(sample_req),
    .sample_in (sample_in),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .sdata     (sdata)
  );

  // Synthesiser stand-in: sample valid only across the capture edge two clks after the request.
  initial begin : responder
    sample_in = JUNK;
    forever begin
      @(negedge clk);
      if (sample_req === 1'b1) begin
        @(negedge clk);
        sample_in = next_sample;
        @(negedge clk);
        sample_in = JUNK;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n, input int drop_at, input int drop_len);
    for (int k = 0; k < n; k++) begin
      sc[k] = sclk;
      lr[k] = lrclk;
      sd[k] = sdata;
      rq[k] = sample_req;
      if (drop_len > 0) en = !(k >= drop_at && k < drop_at + drop_len);
      step();
    end
  endtask

  // k counts clks from the frame-start edge; returns {sclk, lrclk, sample_req}.
  function automatic logic [2:0] exp_tim(input int k, input int req_k);
    logic s, l, r;
    s = ((k / 2) % 2) == 1;
    l = (k % 256) >= 128;
    r = (k == req_k);
    return {s, l, r};
  endfunction

  function automatic logic exp_sd(input logic [W-1:0] h, input int k);
    int p;
    p = ((k % 256) / 4) % 32;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    if (p < 24) return h[23-p];
`else
    if (p >= 1 && p <= 24) return h[24-p];
`endif
    return 1'b0;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b0;
    next_sample = '0;
    step();
    step();
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b expected 0", lrclk); end
    checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b expected 0", sdata); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", sample_req); end
  endtask

  task automatic test_idle;
    int bad;
    rst = 1'b0;
    capture(8, 0, 0);
    bad = 0;
    for (int k = 0; k < 8; k++) if ({sc[k], lr[k], sd[k], rq[k]} !== 4'b0000) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_first_frame;
    int bad, first;
    next_sample = 24'hA5C3F1;
    en = 1'b1;
    step();
    capture(256, 0, 0);
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if ({sc[k], lr[k], rq[k]} !== exp_tim(k, 252)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL first_timing: %0d bad, k=%0d got %b expected %b", bad, first, {sc[first], lr[first], rq[first]}, exp_tim(first, 252)); end
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if (sd[k] !== 1'b0) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL first_sdata: %0d bad, k=%0d got %b expected 0", bad, first, sd[first]); end
  endtask

  task automatic test_data_frame;
    int bad, first;
    next_sample = 24'h800000;
    capture(256, 0, 0);
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if ({sc[k], lr[k], rq[k]} !== exp_tim(k, 252)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL data_timing: %0d bad, k=%0d got %b expected %b", bad, first, {sc[first], lr[first], rq[first]}, exp_tim(first, 252)); end
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if (sd[k] !== exp_sd(24'hA5C3F1, k)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL data_sdata: %0d bad, k=%0d got %b expected %b", bad, first, sd[first], exp_sd(24'hA5C3F1, first)); end
    checks++; if (sd[MSB_K] !== 1'b1 || sd[128 + MSB_K] !== 1'b1) begin errors++; $display("FAIL data_msb_pos: got L=%b R=%b expected 1 1", sd[MSB_K], sd[128 + MSB_K]); end
  endtask

  task automatic test_full_scale;
    int bad, first;
    next_sample = 24'hFFFFFF;
    capture(256, 0, 0);
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if (sd[k] !== exp_sd(24'h800000, k)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL fullscale_sdata: %0d bad, k=%0d got %b expected %b", bad, first, sd[first], exp_sd(24'h800000, first)); end
    bad = 0;
    for (int k = 0; k < 256; k++) if (sd[k] === 1'b1) bad++;
    checks++; if (bad != 8) begin errors++; $display("FAIL fullscale_ones: got %0d high cycles expected 8", bad); end
  endtask

  task automatic test_en_glitch;
    int bad, first;
    next_sample = 24'h6B1D2E;
    capture(256, 60, 10);
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if ({sc[k], lr[k], rq[k]} !== exp_tim(k, 252)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_timing: %0d bad, k=%0d got %b expected %b", bad, first, {sc[first], lr[first], rq[first]}, exp_tim(first, 252)); end
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if (sd[k] !== exp_sd(24'hFFFFFF, k)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_sdata: %0d bad, k=%0d got %b expected %b", bad, first, sd[first], exp_sd(24'hFFFFFF, first)); end
  endtask

  task automatic test_drain;
    int bad, first;
    logic [2:0] et;
    logic ed;
    capture(268, 64, 1000);
    bad = 0; first = 0;
    for (int k = 0; k < 268; k++) begin
      et = (k < 256) ? exp_tim(k, -1) : 3'b000;
      if ({sc[k], lr[k], rq[k]} !== et) begin if (bad == 0) first = k; bad++; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_timing: %0d bad, first k=%0d got %b", bad, first, {sc[first], lr[first], rq[first]}); end
    bad = 0; first = 0;
    for (int k = 0; k < 268; k++) begin
      ed = (k < 256) ? exp_sd(24'h6B1D2E, k) : 1'b0;
      if (sd[k] !== ed) begin if (bad == 0) first = k; bad++; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_sdata: %0d bad, first k=%0d got %b", bad, first, sd[first]); end
  endtask

  task automatic test_reset_mid;
    int bad, first;
    next_sample = 24'h123456;
    en = 1'b1;
    step();
    capture(162, 0, 0);
    bad = 0; first = 0;
    for (int k = 0; k < 162; k++) if ({sc[k], lr[k], rq[k], sd[k]} !== {exp_tim(k, 252), exp_sd(24'h6B1D2E, k)}) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_hold_frame: %0d bad, first k=%0d", bad, first); end
    checks++; if ({sclk, lrclk} !== 2'b11) begin errors++; $display("FAIL prereset_active: got %b expected 11", {sclk, lrclk}); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({sclk, lrclk, sdata, sample_req} !== 4'b0000) begin errors++; $display("FAIL async_reset: got %b expected 0000", {sclk, lrclk, sdata, sample_req}); end
    step();
    step();
    rst = 1'b0;
    step();
    capture(256, 0, 0);
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if ({sc[k], lr[k], rq[k]} !== exp_tim(k, 252)) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL postreset_timing: %0d bad, k=%0d got %b expected %b", bad, first, {sc[first], lr[first], rq[first]}, exp_tim(first, 252)); end
    bad = 0; first = 0;
    for (int k = 0; k < 256; k++) if (sd[k] !== 1'b0) begin if (bad == 0) first = k; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL postreset_sdata: %0d bad, k=%0d got %b expected 0", bad, first, sd[first]); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_frame();
    test_data_frame();
    test_full_scale();
    test_en_glitch();
    test_drain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
